apb_interconnect: RTL

APB_INTERCONNECT -- requirements
Module: apb_interconnect

---
 rtl/apb_interconnect.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/apb_interconnect.sv
// APB address decoder / response mux: routes one master to NUM_SLAVES slaves,
// aborts decode misses and stalled slaves, and keeps a sticky first-fault record.
module apb_interconnect #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 5,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE  = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_LIMIT = '0,
  parameter int TIMEOUT = 255
) (
  input  logic                             pclk,
  input  logic                             reset,
  input  logic [ADDR_WIDTH-1:0]            paddr,
  input  logic                             psel,
  input  logic                             penable,
  input  logic                             pwrite,
  output logic [DATA_WIDTH-1:0]            prdata,
  output logic                             pready,
  output logic                             perr,
  output logic [NUM_SLAVES-1:0]            s_sel,
  output logic [NUM_SLAVES-1:0]            s_enable,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_SLAVES-1:0]            s_ready,
  input  logic [NUM_SLAVES-1:0]            s_perr,
  input  logic                             fault_clear,
  output logic                             fault_valid,
  output logic [1:0]                       fault_code,
  output logic [ADDR_WIDTH-1:0]            fault_addr,
  output logic [7:0]                       fault_count
);
  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  r_state;
  logic [IW-1:0]           r_idx;
  logic                    r_hit;
  logic [TW-1:0]           r_timer;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_fault_valid;
  logic [1:0]              r_fault_code;
  logic [ADDR_WIDTH-1:0]   r_fault_addr;
  logic [7:0]              r_fault_count;

  logic                    w_hit;
  logic [IW-1:0]           w_idx;
  logic                    w_acc;
  logic                    w_tmo;
  logic                    w_fault;
  logic [1:0]              w_code;
  logic [NUM_SLAVES-1:0]   w_sel;
  logic [NUM_SLAVES-1:0]   w_en;
  logic                    w_pready;
  logic                    w_perr;
  logic [DATA_WIDTH-1:0]   w_prdata;

  // Lowest-numbered matching region wins.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!w_hit &&
          (paddr >= SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
          (paddr <= SLAVE_LIMIT[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        w_hit = 1'b1;
        w_idx = IW'(i);
      end
    end
  end

  assign w_acc = (r_state == ACCESS);
  assign w_tmo = w_acc && r_hit && (r_timer == TMO);

  always_comb begin
    w_sel    = '0;
    w_en     = '0;
    w_pready = 1'b0;
    w_perr   = 1'b0;
    w_prdata = '0;
    if (!reset) begin
      if (!w_acc) begin
        if (psel && !penable && w_hit) w_sel[w_idx] = 1'b1;
      end else if (!r_hit || w_tmo) begin
        w_pready = 1'b1;
        w_perr   = 1'b1;
      end else begin
        w_sel[r_idx] = psel;
        w_en[r_idx]  = penable;
        w_pready     = s_ready[r_idx];
        w_perr       = s_ready[r_idx] & s_perr[r_idx];
        if (s_ready[r_idx] && !pwrite)
          w_prdata = s_data[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_fault = w_acc && psel && penable && w_pready && w_perr;
  assign w_code  = !r_hit ? 2'b01 : (w_tmo ? 2'b10 : 2'b11);

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_hit         <= 1'b0;
      r_timer       <= '0;
      r_addr        <= '0;
      r_fault_valid <= 1'b0;
      r_fault_code  <= '0;
      r_fault_addr  <= '0;
      r_fault_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (psel && !penable) begin
            r_state <= ACCESS;
            r_idx   <= w_idx;
            r_hit   <= w_hit;
            r_timer <= '0;
            r_addr  <= paddr;
          end
        end
        ACCESS: begin
          if (!psel || (w_pready && penable))
            r_state <= IDLE;
          else if (r_hit && !s_ready[r_idx] && (r_timer != TMO))
            r_timer <= r_timer + 1'b1;
        end
        default: r_state <= IDLE;
      endcase

      // A fault landing with fault_clear starts a fresh record.
      if (w_fault) begin
        if (fault_clear)
          r_fault_count <= 8'd1;
        else if (r_fault_count != 8'hFF)
          r_fault_count <= r_fault_count + 8'd1;
        if (fault_clear || !r_fault_valid) begin
          r_fault_valid <= 1'b1;
          r_fault_code  <= w_code;
          r_fault_addr  <= r_addr;
        end
      end else if (fault_clear) begin
        r_fault_valid <= 1'b0;
        r_fault_code  <= '0;
        r_fault_addr  <= '0;
        r_fault_count <= '0;
      end
    end
  end

  assign s_sel       = w_sel;
  assign s_enable    = w_en;
  assign pready      = w_pready;
  assign perr        = w_perr;
  assign prdata      = w_prdata;
  assign fault_valid = r_fault_valid;
  assign fault_code  = r_fault_code;
  assign fault_addr  = r_fault_addr;
  assign fault_count = r_fault_count;
endmodule
